// File: rtl/gemm_result_drain.sv
// ============================================================================
// gemm_result_drain : captures a GEMM result matrix and streams it row-major
//                     with a per-frame checksum and frame counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gemm_result_drain #(
    parameter int DATA_WIDTH    = 32,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    localparam int ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1,
    localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1
) (
    input  logic                                          iclk,
    input  logic                                          irst,
    input  logic                                          res_valid,
    output logic                                          res_ready,
    input  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] res_flat,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_WIDTH-1:0]                         m_data,
    output logic [ROW_W-1:0]                              m_row,
    output logic [COL_W-1:0]                              m_col,
    output logic                                          m_last,
    output logic                                          frame_done,
    output logic [DATA_WIDTH-1:0]                         checksum,
    output logic [15:0]                                   frame_count,
    output logic                                          drop_err
);

    localparam int N     = MATRIX_WIDTH * MATRIX_HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [N];
    logic [DATA_WIDTH-1:0] buf_d [N];
    logic [ROW_W-1:0]      row_q, row_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic                  frame_done_q, frame_done_d;
    logic                  drop_err_q, drop_err_d;

    logic [IDX_W-1:0]      idx;
    logic                  row_end;
    logic                  last_elem;
    logic                  accept;
    logic                  xfer;

    assign idx       = IDX_W'(row_q) * IDX_W'(MATRIX_WIDTH) + IDX_W'(col_q);
    assign row_end   = (col_q == COL_W'(MATRIX_WIDTH - 1));
    assign last_elem = row_end && (row_q == ROW_W'(MATRIX_HEIGHT - 1));
    assign accept    = (state_q == ST_IDLE) && res_valid;
    assign xfer      = (state_q == ST_STREAM) && m_ready;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (res_valid) state_d = ST_STREAM;
            ST_STREAM: if (m_ready && last_elem) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Data output is forced to zero outside STREAM so reset/idle values are clean
    always_comb begin
        res_ready = (state_q == ST_IDLE);
        m_valid   = (state_q == ST_STREAM);
        m_last    = (state_q == ST_STREAM) && last_elem;
        m_data    = (state_q == ST_STREAM) ? buf_q[idx] : '0;
        m_row     = row_q;
        m_col     = col_q;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            buf_d[k] = buf_q[k];
        end
        row_d         = row_q;
        col_d         = col_q;
        sum_d         = sum_q;
        checksum_d    = checksum_q;
        frame_count_d = frame_count_q;
        frame_done_d  = 1'b0;
        drop_err_d    = drop_err_q | (res_valid && (state_q != ST_IDLE));

        if (accept) begin
            for (int k = 0; k < N; k++) begin
                buf_d[k] = res_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
            row_d = '0;
            col_d = '0;
            sum_d = '0;
        end

        if (xfer) begin
            sum_d = sum_q + buf_q[idx];
            if (last_elem) begin
                row_d         = '0;
                col_d         = '0;
                checksum_d    = sum_q + buf_q[idx];
                frame_count_d = frame_count_q + 16'd1;
                frame_done_d  = 1'b1;
            end else if (row_end) begin
                row_d = row_q + ROW_W'(1);
                col_d = '0;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            row_q         <= '0;
            col_q         <= '0;
            sum_q         <= '0;
            checksum_q    <= '0;
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
            drop_err_q    <= 1'b0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            sum_q         <= sum_d;
            checksum_q    <= checksum_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
            drop_err_q    <= drop_err_d;
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset
    always_ff @(posedge iclk) begin
        for (int k = 0; k < N; k++) begin
            buf_q[k] <= buf_d[k];
        end
    end

    assign frame_done  = frame_done_q;
    assign checksum    = checksum_q;
    assign frame_count = frame_count_q;
    assign drop_err    = drop_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gemm_result_drain.sv
// ============================================================================
// tb_gemm_result_drain : directed self-checking bench for gemm_result_drain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gemm_result_drain;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic            iclk = 1'b0;
    logic            irst = 1'b0;
    logic            res_valid = 1'b0;
    logic            res_ready;
    logic [N*DW-1:0] res_flat = '0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW-1:0]   m_data;
    logic [1:0]      m_row;
    logic [1:0]      m_col;
    logic            m_last;
    logic            frame_done;
    logic [DW-1:0]   checksum;
    logic [15:0]     frame_count;
    logic            drop_err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] got_data [N];
    logic [1:0]    got_row  [N];
    logic [1:0]    got_col  [N];
    logic          got_last [N];
    int            n_xfer, n_stalls, stall_bad, timed_out;
    logic          first_valid;
    logic [15:0]   exp_fc;

    always #5 iclk = ~iclk;

    gemm_result_drain #(.DATA_WIDTH(DW), .MATRIX_WIDTH(W), .MATRIX_HEIGHT(H)) dut (
        .iclk(iclk), .irst(irst),
        .res_valid(res_valid), .res_ready(res_ready), .res_flat(res_flat),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_row(m_row), .m_col(m_col), .m_last(m_last),
        .frame_done(frame_done), .checksum(checksum),
        .frame_count(frame_count), .drop_err(drop_err)
    );

    // mode 0: k+1, 1: 100+k, 2: 0x40000000, 3: 3*k
    function automatic logic [DW-1:0] elem(input int mode, input int k);
        case (mode)
            0:       return DW'(k + 1);
            1:       return DW'(100 + k);
            2:       return 32'h4000_0000;
            default: return DW'(3 * k);
        endcase
    endfunction

    function automatic logic [N*DW-1:0] make_mat(input int mode);
        logic [N*DW-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) m[k*DW +: DW] = elem(mode, k);
        return m;
    endfunction

    // Drives m_ready per pattern and records every transfer until N are seen.
    task automatic stream_frame(input int pat, input int drop_at,
                                input logic [N*DW-1:0] drop_mat, input bit keep_valid);
        int            cyc;
        bit            dropped, prev_stall;
        logic [DW-1:0] pd;
        logic [1:0]    pr, pc;
        logic          pl;
        n_xfer = 0; n_stalls = 0; stall_bad = 0; timed_out = 0;
        first_valid = 1'b0; cyc = 0; dropped = 0; prev_stall = 0;
        pd = '0; pr = '0; pc = '0; pl = 1'b0;
        while (n_xfer < N) begin
            @(negedge iclk);
            if (cyc == 0) first_valid = m_valid;
            m_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (drop_at >= 0 && n_xfer == drop_at && !dropped) begin
                res_valid = 1'b1;
                res_flat  = drop_mat;
                dropped   = 1;
            end else begin
                res_valid = keep_valid;
            end
            if (prev_stall && ({m_data, m_row, m_col, m_last} !== {pd, pr, pc, pl}))
                stall_bad++;
            prev_stall = m_valid && !m_ready;
            if (prev_stall) n_stalls++;
            pd = m_data; pr = m_row; pc = m_col; pl = m_last;
            if (m_valid && m_ready) begin
                got_data[n_xfer] = m_data;
                got_row[n_xfer]  = m_row;
                got_col[n_xfer]  = m_col;
                got_last[n_xfer] = m_last;
                n_xfer++;
            end
            cyc++;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        irst = 1'b0; res_valid = 1'b0; m_ready = 1'b0; res_flat = '0;
        repeat (3) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        checks++;
        if ({res_ready, m_valid, m_last, frame_done, drop_err, m_row, m_col, m_data, checksum, frame_count}
            !== {1'b1, 88'd0}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h",
                     {res_ready, m_valid, m_last, frame_done, drop_err, m_row, m_col, m_data, checksum, frame_count},
                     {1'b1, 88'd0});
        end
        exp_fc = 16'd0;
    endtask

    task automatic test_basic_frame();
        int err, lerr;
        @(negedge iclk);
        res_flat = make_mat(0); res_valid = 1'b1; m_ready = 1'b1;
        stream_frame(0, -1, '0, 1'b0);
        exp_fc = exp_fc + 16'd1;
        checks++;
        if (first_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", first_valid); end
        checks++;
        if (timed_out != 0) begin failures++; $display("FAIL basic_timeout transfers=%0d exp=%0d", n_xfer, N); end
        err = 0; lerr = 0;
        for (int i = 0; i < N; i++) begin
            if (got_data[i] !== elem(0, i) || got_row[i] !== 2'(i / W) || got_col[i] !== 2'(i % W)) err++;
            if (got_last[i] !== (i == N - 1)) lerr++;
        end
        checks++;
        if (err != 0) begin failures++; $display("FAIL basic_order mismatches=%0d exp=0", err); end
        checks++;
        if (lerr != 0) begin failures++; $display("FAIL basic_last mismatches=%0d exp=0", lerr); end
        @(negedge iclk);
        checks++;
        if ({frame_done, res_ready, m_valid} !== 3'b110) begin
            failures++; $display("FAIL basic_done flags=%b exp=110", {frame_done, res_ready, m_valid});
        end
        checks++;
        if (checksum !== 32'd136) begin failures++; $display("FAIL basic_checksum got=%0d exp=136", checksum); end
        checks++;
        if (frame_count !== exp_fc) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", frame_count, exp_fc); end
        @(negedge iclk);
        checks++;
        if (frame_done !== 1'b0 || checksum !== 32'd136) begin
            failures++; $display("FAIL basic_pulse done=%b sum=%0d exp done=0 sum=136", frame_done, checksum);
        end
    endtask

    task automatic test_backpressure();
        int err;
        @(negedge iclk);
        res_flat = make_mat(0); res_valid = 1'b1;
        stream_frame(1, -1, '0, 1'b0);
        exp_fc = exp_fc + 16'd1;
        err = 0;
        for (int i = 0; i < N; i++)
            if (got_data[i] !== elem(0, i) || got_row[i] !== 2'(i / W) || got_col[i] !== 2'(i % W)) err++;
        checks++;
        if (timed_out != 0 || err != 0) begin
            failures++; $display("FAIL bp_order mismatches=%0d timeout=%0d exp=0", err, timed_out);
        end
        checks++;
        if (stall_bad != 0) begin failures++; $display("FAIL bp_stable changes=%0d exp=0", stall_bad); end
        checks++;
        if (n_stalls == 0) begin failures++; $display("FAIL bp_stalls got=%0d exp>0", n_stalls); end
        @(negedge iclk);
        checks++;
        if (frame_done !== 1'b1 || checksum !== 32'd136 || frame_count !== exp_fc) begin
            failures++;
            $display("FAIL bp_result done=%b sum=%0d cnt=%0d exp 1/136/%0d", frame_done, checksum, frame_count, exp_fc);
        end
    endtask

    task automatic test_drop_busy();
        int err;
        checks++;
        if (drop_err !== 1'b0) begin failures++; $display("FAIL drop_pre got=%b exp=0", drop_err); end
        @(negedge iclk);
        res_flat = make_mat(0); res_valid = 1'b1;
        stream_frame(0, 4, make_mat(1), 1'b0);
        exp_fc = exp_fc + 16'd1;
        err = 0;
        for (int i = 0; i < N; i++) if (got_data[i] !== elem(0, i)) err++;
        checks++;
        if (timed_out != 0 || err != 0) begin
            failures++; $display("FAIL drop_original mismatches=%0d timeout=%0d exp=0", err, timed_out);
        end
        @(negedge iclk);
        checks++;
        if (drop_err !== 1'b1 || checksum !== 32'd136) begin
            failures++; $display("FAIL drop_flag err=%b sum=%0d exp err=1 sum=136", drop_err, checksum);
        end
        res_flat = make_mat(3); res_valid = 1'b1;
        stream_frame(0, -1, '0, 1'b0);
        exp_fc = exp_fc + 16'd1;
        err = 0;
        for (int i = 0; i < N; i++) if (got_data[i] !== elem(3, i)) err++;
        checks++;
        if (first_valid !== 1'b1 || timed_out != 0 || err != 0) begin
            failures++; $display("FAIL drop_next mismatches=%0d first=%b exp=0/1", err, first_valid);
        end
        @(negedge iclk);
        checks++;
        if (checksum !== 32'd360 || drop_err !== 1'b1 || frame_count !== exp_fc) begin
            failures++;
            $display("FAIL drop_next_result sum=%0d err=%b cnt=%0d exp 360/1/%0d", checksum, drop_err, frame_count, exp_fc);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge iclk);
        res_flat = make_mat(2); res_valid = 1'b1;
        stream_frame(0, -1, '0, 1'b1);
        exp_fc = exp_fc + 16'd1;
        @(negedge iclk);
        checks++;
        if (frame_done !== 1'b1 || checksum !== 32'h0 || frame_count !== exp_fc) begin
            failures++;
            $display("FAIL b2b_first done=%b sum=%h cnt=%0d exp 1/0/%0d", frame_done, checksum, frame_count, exp_fc);
        end
        stream_frame(0, -1, '0, 1'b0);
        exp_fc = exp_fc + 16'd1;
        checks++;
        if (first_valid !== 1'b1 || timed_out != 0 || got_data[N-1] !== 32'h4000_0000) begin
            failures++; $display("FAIL b2b_accept first=%b timeout=%0d exp 1/0", first_valid, timed_out);
        end
        @(negedge iclk);
        checks++;
        if (frame_done !== 1'b1 || checksum !== 32'h0 || frame_count !== exp_fc) begin
            failures++;
            $display("FAIL b2b_second done=%b sum=%h cnt=%0d exp 1/0/%0d", frame_done, checksum, frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, err;
        @(negedge iclk);
        res_flat = make_mat(0); res_valid = 1'b1; m_ready = 1'b1;
        @(negedge iclk);
        res_valid = 1'b0;
        cyc = 0;
        while (m_data !== 32'd9 && cyc < 40) begin
            @(negedge iclk);
            cyc++;
        end
        checks++;
        if (cyc >= 40) begin failures++; $display("FAIL midrst_reach got=%0d exp=9", m_data); end
        #1 irst = 1'b0;
        #1;
        checks++;
        if ({res_ready, m_valid, m_last, frame_done, drop_err, m_row, m_col, m_data, checksum, frame_count}
            !== {1'b1, 88'd0}) begin
            failures++;
            $display("FAIL midrst_async got=%h exp=%h",
                     {res_ready, m_valid, m_last, frame_done, drop_err, m_row, m_col, m_data, checksum, frame_count},
                     {1'b1, 88'd0});
        end
        @(negedge iclk);
        @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        checks++;
        if (frame_count !== 16'd0 || m_valid !== 1'b0 || res_ready !== 1'b1) begin
            failures++; $display("FAIL midrst_after cnt=%0d valid=%b ready=%b exp 0/0/1", frame_count, m_valid, res_ready);
        end
        res_flat = make_mat(1); res_valid = 1'b1;
        stream_frame(0, -1, '0, 1'b0);
        err = 0;
        for (int i = 0; i < N; i++)
            if (got_data[i] !== elem(1, i) || got_row[i] !== 2'(i / W) || got_col[i] !== 2'(i % W)) err++;
        checks++;
        if (timed_out != 0 || err != 0) begin
            failures++; $display("FAIL midrst_fresh mismatches=%0d timeout=%0d exp=0", err, timed_out);
        end
        @(negedge iclk);
        checks++;
        if (frame_count !== 16'd1 || checksum !== 32'd1720) begin
            failures++; $display("FAIL midrst_count cnt=%0d sum=%0d exp 1/1720", frame_count, checksum);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_drop_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
